// File: rtl/tim_capture_if.sv
// Register-side handshake between tim_capture and the core: control in,
// measurement results and status flags out.
interface tim_capture_if #(
    parameter int CNT_W = 16
);
    logic             cap_en;
    logic [CNT_W-1:0] cap_psc;
    logic             cap_ack;
    logic [CNT_W-1:0] cap_period;
    logic [CNT_W-1:0] cap_high;
    logic             cap_valid;
    logic             cap_ovr;
    logic             cap_timeout;
    logic             cap_irq;

    // core side
    modport master (
        output cap_en, cap_psc, cap_ack,
        input  cap_period, cap_high, cap_valid, cap_ovr, cap_timeout, cap_irq
    );

    // capture block side
    modport slave (
        input  cap_en, cap_psc, cap_ack,
        output cap_period, cap_high, cap_valid, cap_ovr, cap_timeout, cap_irq
    );
endinterface

// File: rtl/tim_capture.sv
// Input capture: measures period and high time of cap_in in prescaled ticks
// and publishes each completed period through a valid/ack handshake.
module tim_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap_in,
    tim_capture_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       psc_cnt_q, psc_cnt_d;
    logic [CNT_W-1:0]       hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0]       cap_period_q, cap_period_d;
    logic [CNT_W-1:0]       cap_high_q, cap_high_d;
    logic                   cap_valid_q, cap_valid_d;
    logic                   cap_ovr_q, cap_ovr_d;
    logic                   cap_timeout_q, cap_timeout_d;
    logic                   cap_irq_q, cap_irq_d;

    logic sync_lvl, rise, fall, tick, publish, tmo_evt;
    logic [CNT_W-1:0] cnt_inc;

    // Synchroniser shift and edge history
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], cap_in};
        sync_lvl = sync_q[SYNC_STAGES-1];
        hist_d   = sync_lvl;
        rise     = sync_lvl & ~hist_q;
        fall     = ~sync_lvl & hist_q;
    end

    // Measurement FSM: prescaled tick counting, edge handling, timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        psc_cnt_d = psc_cnt_q;
        hi_lat_d  = hi_lat_q;
        publish   = 1'b0;
        tmo_evt   = 1'b0;
        tick      = (psc_cnt_q == bus.cap_psc);
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        if (!bus.cap_en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            psc_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d     = '0;
                    psc_cnt_d = '0;
                    state_d   = ARM;
                end
                ARM: begin
                    // first rise only starts the count; falls are ignored
                    if (rise) begin
                        cnt_d     = CNT_ONE;
                        psc_cnt_d = '0;
                        state_d   = HIGH;
                    end
                end
                HIGH, LOW: begin
                    if (tick) begin
                        psc_cnt_d = '0;
                        cnt_d     = cnt_inc;
                    end else begin
                        psc_cnt_d = psc_cnt_q + CNT_ONE;
                    end
                    if (state_q == HIGH && fall) begin
                        hi_lat_d = cnt_q;
                        state_d  = LOW;
                    end else if (state_q == LOW && rise) begin
                        // this rise closes one period and opens the next
                        publish   = 1'b1;
                        cnt_d     = CNT_ONE;
                        psc_cnt_d = '0;
                        state_d   = HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        tmo_evt = 1'b1;
                        state_d = ARM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Result registers and sticky flags; a new event wins over ack
    always_comb begin
        cap_period_d  = cap_period_q;
        cap_high_d    = cap_high_q;
        cap_valid_d   = cap_valid_q;
        cap_ovr_d     = cap_ovr_q;
        cap_timeout_d = cap_timeout_q;
        cap_irq_d     = publish;

        if (bus.cap_ack) begin
            cap_valid_d   = 1'b0;
            cap_ovr_d     = 1'b0;
            cap_timeout_d = 1'b0;
        end
        if (publish) begin
            cap_period_d = cnt_q;
            cap_high_d   = hi_lat_q;
            cap_valid_d  = 1'b1;
            // overwrite only counts as lost data if the core did not read it
            if (cap_valid_q && !bus.cap_ack) cap_ovr_d = 1'b1;
        end
        if (tmo_evt) cap_timeout_d = 1'b1;
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            hist_q        <= 1'b0;
            cnt_q         <= '0;
            psc_cnt_q     <= '0;
            hi_lat_q      <= '0;
            cap_period_q  <= '0;
            cap_high_q    <= '0;
            cap_valid_q   <= 1'b0;
            cap_ovr_q     <= 1'b0;
            cap_timeout_q <= 1'b0;
            cap_irq_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            hist_q        <= hist_d;
            cnt_q         <= cnt_d;
            psc_cnt_q     <= psc_cnt_d;
            hi_lat_q      <= hi_lat_d;
            cap_period_q  <= cap_period_d;
            cap_high_q    <= cap_high_d;
            cap_valid_q   <= cap_valid_d;
            cap_ovr_q     <= cap_ovr_d;
            cap_timeout_q <= cap_timeout_d;
            cap_irq_q     <= cap_irq_d;
        end
    end

    assign bus.cap_period  = cap_period_q;
    assign bus.cap_high    = cap_high_q;
    assign bus.cap_valid   = cap_valid_q;
    assign bus.cap_ovr     = cap_ovr_q;
    assign bus.cap_timeout = cap_timeout_q;
    assign bus.cap_irq     = cap_irq_q;

endmodule

// File: tb/tb_tim_capture.sv
// Directed bench for tim_capture: table of waveforms with expected results,
// plus hand sequences for overwrite, coincident ack, timeout, enable drop
// and reset abort.
module tb_tim_capture;
    localparam int CNT_W = 16;

    typedef struct {
        logic [CNT_W-1:0] psc;
        int               hi;
        int               lo;
        int               nper;
        logic [CNT_W-1:0] exp_period;
        logic [CNT_W-1:0] exp_high;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cap_in = 1'b0;

    tim_capture_if #(.CNT_W(CNT_W)) bus ();

    tim_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .cap_in (cap_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int irq_cnt = 0;
    logic auto_ack = 1'b0;
    logic chk_en = 1'b0;
    logic [CNT_W-1:0] exp_period = '0;
    logic [CNT_W-1:0] exp_high = '0;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one clock; observe irq and optionally ack each publish
    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_ack) bus.cap_ack = 1'b0;
        if (bus.cap_irq) begin
            irq_cnt++;
            if (chk_en) begin
                check("pub_period", 32'(bus.cap_period), 32'(exp_period));
                check("pub_high", 32'(bus.cap_high), 32'(exp_high));
                check("pub_valid", 32'(bus.cap_valid), 32'd1);
                if (auto_ack) check("pub_ovr", 32'(bus.cap_ovr), 32'd0);
            end
            if (auto_ack) bus.cap_ack = 1'b1;
        end
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic drive_hl(input int hi, input int lo);
        cap_in = 1'b1;
        cycn(hi);
        cap_in = 1'b0;
        cycn(lo);
    endtask

    task automatic restart();
        bus.cap_en = 1'b0;
        cap_in = 1'b0;
        cycn(5);
        bus.cap_en = 1'b1;
        cyc();
    endtask

    task automatic clear();
        bus.cap_ack = 1'b1;
        cyc();
        bus.cap_ack = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, 32'(bus.cap_period), 32'd0);
        check({tag, "_high"}, 32'(bus.cap_high), 32'd0);
        check({tag, "_valid"}, 32'(bus.cap_valid), 32'd0);
        check({tag, "_ovr"}, 32'(bus.cap_ovr), 32'd0);
        check({tag, "_timeout"}, 32'(bus.cap_timeout), 32'd0);
        check({tag, "_irq"}, 32'(bus.cap_irq), 32'd0);
    endtask

    initial begin
        int tmo_at;
        logic v0;
        logic [CNT_W-1:0] p0;

        //            psc  hi  lo nper period high
        vecs[0] = '{16'd0,  3,  5, 4, 16'd8,   16'd3};
        vecs[1] = '{16'd1,  5,  5, 4, 16'd5,   16'd3};
        vecs[2] = '{16'd0,  4,  4, 3, 16'd8,   16'd4};
        vecs[3] = '{16'd2,  7,  5, 3, 16'd4,   16'd3};
        vecs[4] = '{16'd0, 25, 75, 3, 16'd100, 16'd25};
        vecs[5] = '{16'd3, 10,  6, 3, 16'd4,   16'd3};

        bus.cap_en = 1'b0;
        bus.cap_psc = '0;
        bus.cap_ack = 1'b0;
        cycn(3);
        check_zero("reset");
        reset = 1'b1;
        cycn(2);

        // table-driven periodic waveforms, every publish acked
        for (int v = 0; v < 6; v++) begin
            auto_ack = 1'b0;
            clear();
            bus.cap_psc = vecs[v].psc;
            restart();
            exp_period = vecs[v].exp_period;
            exp_high = vecs[v].exp_high;
            chk_en = 1'b1;
            auto_ack = 1'b1;
            irq_cnt = 0;
            for (int p = 0; p < vecs[v].nper; p++) drive_hl(vecs[v].hi, vecs[v].lo);
            bus.cap_ack = 1'b0;
            auto_ack = 1'b0;
            check($sformatf("vec%0d_irq_count", v), irq_cnt, vecs[v].nper - 1);
        end

        // two publishes without ack: second overwrites and flags overrun
        bus.cap_psc = '0;
        clear();
        restart();
        chk_en = 1'b0;
        drive_hl(3, 5);
        drive_hl(4, 6);
        cap_in = 1'b1;
        cycn(4);
        check("ovr_period", 32'(bus.cap_period), 32'd10);
        check("ovr_high", 32'(bus.cap_high), 32'd4);
        check("ovr_valid", 32'(bus.cap_valid), 32'd1);
        check("ovr_flag", 32'(bus.cap_ovr), 32'd1);
        clear();
        check("ack_valid", 32'(bus.cap_valid), 32'd0);
        check("ack_ovr", 32'(bus.cap_ovr), 32'd0);

        // publish in the same cycle as ack
        restart();
        chk_en = 1'b1;
        exp_period = 16'd8;
        exp_high = 16'd3;
        drive_hl(3, 5);
        drive_hl(3, 5);
        check("coin_pre_valid", 32'(bus.cap_valid), 32'd1);
        cap_in = 1'b1;
        cycn(2);
        bus.cap_ack = 1'b1;
        cyc();
        bus.cap_ack = 1'b0;
        check("coin_irq", 32'(bus.cap_irq), 32'd1);
        check("coin_valid", 32'(bus.cap_valid), 32'd1);
        check("coin_ovr", 32'(bus.cap_ovr), 32'd0);

        // high held until the counter saturates
        restart();
        chk_en = 1'b0;
        irq_cnt = 0;
        v0 = bus.cap_valid;
        p0 = bus.cap_period;
        cap_in = 1'b1;
        tmo_at = 0;
        for (int n = 1; n <= 70000 && tmo_at == 0; n++) begin
            cyc();
            if (bus.cap_timeout) tmo_at = n;
        end
        check("tmo_cycle", tmo_at, 65538);
        check("tmo_no_irq", irq_cnt, 0);
        check("tmo_valid_held", 32'(bus.cap_valid), 32'(v0));
        check("tmo_period_held", 32'(bus.cap_period), 32'(p0));
        cycn(10);
        check("tmo_armed_no_irq", irq_cnt, 0);
        cap_in = 1'b0;
        cycn(5);
        chk_en = 1'b1;
        drive_hl(3, 5);
        drive_hl(3, 5);
        check("tmo_recover_irq", irq_cnt, 1);
        check("tmo_sticky", 32'(bus.cap_timeout), 32'd1);
        clear();
        check("tmo_ack", 32'(bus.cap_timeout), 32'd0);

        // enable dropped while HIGH: results held, aborted period not published
        restart();
        drive_hl(3, 5);
        cap_in = 1'b1;
        cycn(4);
        irq_cnt = 0;
        bus.cap_en = 1'b0;
        cyc();
        cap_in = 1'b0;
        cycn(5);
        drive_hl(6, 5);
        check("endrop_irq", irq_cnt, 0);
        check("endrop_valid", 32'(bus.cap_valid), 32'd1);
        check("endrop_period", 32'(bus.cap_period), 32'd8);
        check("endrop_high", 32'(bus.cap_high), 32'd3);

        // reset asserted in LOW
        restart();
        drive_hl(3, 5);
        drive_hl(3, 5);
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        cycn(2);
        reset = 1'b1;
        irq_cnt = 0;
        cap_in = 1'b1;
        cycn(6);
        check("rst_abort_irq", irq_cnt, 0);
        check("rst_abort_valid", 32'(bus.cap_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
